// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath and its sequencer.
//   - Opcode encodings understood by the Calcu block (OP_LAST is the highest legal code).
//   - Sequencer FSM state type.
//   - Bit positions inside the 4-bit calculator flag vector.
package calc_pkg;

  localparam logic [3:0] OP_SUM    = 4'd0;
  localparam logic [3:0] OP_REST   = 4'd1;
  localparam logic [3:0] OP_MOD    = 4'd2;
  localparam logic [3:0] OP_MULT   = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_AND    = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd6;
  localparam logic [3:0] OP_XOR    = 4'd7;
  localparam logic [3:0] OP_LSHIFT = 4'd8;
  localparam logic [3:0] OP_RSHIFT = 4'd9;
  localparam logic [3:0] OP_LAST   = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OVF   = 3;

endpackage

// File: rtl/calcu_req_check.sv
// Combinational legality check for a calculator request.
//   op_i    : requested opcode
//   op_b_i  : operand B as it will be issued
//   legal_o : 1 when the opcode exists and is not a divide/modulo by zero
module calcu_req_check
  import calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [3:0]   op_i,
  input  logic [N-1:0] op_b_i,
  output logic         legal_o
);

  logic in_range;
  logic div_by_zero;

  always_comb begin
    in_range    = (op_i <= OP_LAST);
    div_by_zero = ((op_i == OP_DIV) || (op_i == OP_MOD)) && (op_b_i == '0);
    legal_o     = in_range && !div_by_zero;
  end

endmodule

// File: rtl/calcu_sequencer.sv
// Sequencing controller in front of the combinational Calcu datapath.
// Accepts one request at a time (valid/ready), issues it to the calculator,
// waits one settle cycle, captures result/flags into a response register and
// holds it until consumed. Keeps a chaining accumulator and a saturating count
// of completed operations. Illegal requests are answered with rsp_err and are
// never issued to the calculator.
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : request channel (req_use_acc selects acc as operand A)
//   acc_clear         : synchronous accumulator clear, any state
//   alu_a/b/sel       : operands and selection driven to Calcu
//   alu_result/flags  : Calcu outputs
//   rsp_*             : response channel
//   acc, op_count     : accumulator and completed-operation counter
module calcu_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [3:0]       req_op,
  input  logic             req_use_acc,
  input  logic             acc_clear,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_sel,
  input  logic [N-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [N-1:0]     acc,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t       state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [N-1:0]     rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;
  logic [N-1:0]     acc_q;
  logic [CNT_W-1:0] op_count_q;
  logic [N-1:0]     alu_a_q;
  logic [N-1:0]     alu_b_q;
  logic [3:0]       alu_sel_q;

  logic [N-1:0]     op_a_d;
  logic             legal;

  // Operand A is taken from acc_q, i.e. the value before any same-cycle clear.
  always_comb begin
    op_a_d = req_use_acc ? acc_q : req_a;
  end

  calcu_req_check #(
    .N (N)
  ) u_req_check (
    .op_i    (req_op),
    .op_b_i  (req_b),
    .legal_o (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      acc_q        <= '0;
      op_count_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (legal) begin
              alu_a_q   <= op_a_d;
              alu_b_q   <= req_b;
              alu_sel_q <= req_op;
              state_q   <= EXEC;
            end else begin
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_flags_q  <= '0;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          rsp_err_q    <= 1'b0;
          acc_q        <= alu_result;
          if (op_count_q != '1) begin
            op_count_q <= op_count_q + 1'b1;
          end
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
      // Placed after the case so a clear overrides the EXEC capture.
      if (acc_clear) begin
        acc_q <= '0;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign acc        = acc_q;
  assign op_count   = op_count_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;

endmodule

// File: tb/tb_calcu_sequencer.sv
// Directed bench for calcu_sequencer. A small behavioural calculator model
// stands in for Calcu and answers alu_a/alu_b/alu_sel combinationally.
module tb_calcu_sequencer;
  import calc_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [3:0]       req_op;
  logic             req_use_acc;
  logic             acc_clear;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_sel;
  logic [N-1:0]     alu_result;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calcu_sequencer #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_use_acc (req_use_acc),
    .acc_clear   (acc_clear),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .acc         (acc),
    .op_count    (op_count)
  );

  // Calculator model: flags = {ovf, neg, carry, zero}.
  logic [2*N-1:0] wide;
  always_comb begin
    wide       = '0;
    alu_flags  = '0;
    case (alu_sel)
      OP_SUM:    wide = {4'b0, alu_a} + {4'b0, alu_b};
      OP_REST:   wide = {4'b0, alu_a} - {4'b0, alu_b};
      OP_MOD:    wide = (alu_b != 0) ? {4'b0, alu_a % alu_b} : '0;
      OP_MULT:   wide = {4'b0, alu_a} * {4'b0, alu_b};
      OP_DIV:    wide = (alu_b != 0) ? {4'b0, alu_a / alu_b} : '0;
      OP_AND:    wide = {4'b0, alu_a & alu_b};
      OP_OR:     wide = {4'b0, alu_a | alu_b};
      OP_XOR:    wide = {4'b0, alu_a ^ alu_b};
      OP_LSHIFT: wide = {4'b0, alu_a} << alu_b;
      OP_RSHIFT: wide = {4'b0, alu_a >> alu_b};
      default:   wide = '0;
    endcase
    alu_result            = wide[N-1:0];
    alu_flags[FLAG_ZERO]  = (wide[N-1:0] == 0);
    alu_flags[FLAG_CARRY] = (alu_sel == OP_MULT) ? (wide[2*N-1:N] != 0) : wide[N];
    alu_flags[FLAG_NEG]   = wide[N-1];
    if (alu_sel == OP_SUM)
      alu_flags[FLAG_OVF] = (alu_a[N-1] == alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
    else if (alu_sel == OP_REST)
      alu_flags[FLAG_OVF] = (alu_a[N-1] != alu_b[N-1]) && (wide[N-1] != alu_a[N-1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic use_acc);
    req_valid   = 1'b1;
    req_a       = a;
    req_b       = b;
    req_op      = op;
    req_use_acc = use_acc;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_a = 0; req_b = 0; req_op = 0;
    req_use_acc = 0; acc_clear = 0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);

    // 3 + 5 = 8, flags ovf|neg
    drive_req(4'd3, 4'd5, OP_SUM, 1'b0);
    tick(); req_valid = 0;
    chk("sum_exec_valid", 32'(rsp_valid), 32'd0);
    chk("sum_exec_alu_a", 32'(alu_a), 32'd3);
    chk("sum_exec_alu_b", 32'(alu_b), 32'd5);
    chk("sum_exec_ready", 32'(req_ready), 32'd0);
    tick();
    chk("sum_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sum_rsp_result", 32'(rsp_result), 32'h8);
    chk("sum_rsp_err", 32'(rsp_err), 32'd0);
    chk("sum_rsp_flags", 32'(rsp_flags), 32'hC);
    chk("sum_acc", 32'(acc), 32'd8);
    chk("sum_op_count", 32'(op_count), 32'd1);
    tick();
    chk("sum_idle_valid", 32'(rsp_valid), 32'd0);
    chk("sum_idle_ready", 32'(req_ready), 32'd1);

    // acc(8) - 2 = 6, req_a ignored
    drive_req(4'd15, 4'd2, OP_REST, 1'b1);
    tick(); req_valid = 0; req_use_acc = 0;
    chk("chain_alu_a", 32'(alu_a), 32'd8);
    chk("chain_alu_sel", 32'(alu_sel), 32'(OP_REST));
    tick();
    chk("chain_rsp_result", 32'(rsp_result), 32'd6);
    chk("chain_rsp_flags", 32'(rsp_flags), 32'h8);
    chk("chain_acc", 32'(acc), 32'd6);
    chk("chain_op_count", 32'(op_count), 32'd2);
    tick();

    // Illegal: divide by zero
    drive_req(4'd9, 4'd0, OP_DIV, 1'b0);
    tick(); req_valid = 0;
    chk("div0_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("div0_rsp_err", 32'(rsp_err), 32'd1);
    chk("div0_rsp_result", 32'(rsp_result), 32'd0);
    chk("div0_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("div0_acc", 32'(acc), 32'd6);
    chk("div0_op_count", 32'(op_count), 32'd2);
    chk("div0_alu_sel", 32'(alu_sel), 32'(OP_REST));
    chk("div0_alu_a", 32'(alu_a), 32'd8);
    tick();
    chk("div0_idle_ready", 32'(req_ready), 32'd1);

    // Illegal: modulo by zero
    drive_req(4'd9, 4'd0, OP_MOD, 1'b0);
    tick(); req_valid = 0;
    chk("mod0_rsp_err", 32'(rsp_err), 32'd1);
    chk("mod0_alu_sel", 32'(alu_sel), 32'(OP_REST));
    tick();

    // Illegal: opcode out of range
    drive_req(4'd1, 4'd3, 4'd12, 1'b0);
    tick(); req_valid = 0;
    chk("op12_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op12_rsp_err", 32'(rsp_err), 32'd1);
    chk("op12_rsp_result", 32'(rsp_result), 32'd0);
    chk("op12_alu_sel", 32'(alu_sel), 32'(OP_REST));
    chk("op12_op_count", 32'(op_count), 32'd2);
    tick();

    // Backpressure: 2 * 3 = 6 held while a second request waits
    rsp_ready = 1'b0;
    drive_req(4'd2, 4'd3, OP_MULT, 1'b0);
    tick();
    drive_req(4'd9, 4'd4, OP_AND, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'd6);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_alu_sel", 32'(alu_sel), 32'(OP_MULT));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = 0;
    chk("bp_pend_alu_sel", 32'(alu_sel), 32'(OP_AND));
    chk("bp_pend_alu_a", 32'(alu_a), 32'd9);
    tick();
    chk("bp_pend_result", 32'(rsp_result), 32'd0);
    chk("bp_pend_flags", 32'(rsp_flags), 32'h1);
    chk("bp_pend_op_count", 32'(op_count), 32'd4);
    tick();

    // Reset in EXEC: build acc=5, op_count=2 first
    rst = 1'b1; tick(); rst = 1'b0; tick();
    drive_req(4'd1, 4'd1, OP_SUM, 1'b0);
    tick(); req_valid = 0; tick(); tick();
    drive_req(4'd0, 4'd3, OP_SUM, 1'b1);
    tick(); req_valid = 0; req_use_acc = 0; tick(); tick();
    chk("pre_rst_acc", 32'(acc), 32'd5);
    chk("pre_rst_op_count", 32'(op_count), 32'd2);
    drive_req(4'd1, 4'd1, OP_SUM, 1'b0);
    tick(); req_valid = 0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    chk("exec_rst_acc", 32'(acc), 32'd0);
    chk("exec_rst_op_count", 32'(op_count), 32'd0);
    chk("exec_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("exec_rst_no_rsp", 32'(rsp_valid), 32'd0);

    // acc_clear on the capture cycle of 7 ^ 1
    drive_req(4'd7, 4'd1, OP_XOR, 1'b0);
    tick(); req_valid = 0; acc_clear = 1'b1;
    tick(); acc_clear = 1'b0;
    chk("clr_rsp_result", 32'(rsp_result), 32'd6);
    chk("clr_acc", 32'(acc), 32'd0);
    chk("clr_op_count", 32'(op_count), 32'd1);
    tick();

    // acc_clear alongside a use_acc accept: operand A is the pre-clear acc
    drive_req(4'd4, 4'd2, OP_SUM, 1'b0);
    tick(); req_valid = 0; tick(); tick();
    drive_req(4'd0, 4'd1, OP_SUM, 1'b1); acc_clear = 1'b1;
    tick(); req_valid = 0; req_use_acc = 0; acc_clear = 1'b0;
    chk("clr_acc_alu_a", 32'(alu_a), 32'd6);
    chk("clr_acc_cleared", 32'(acc), 32'd0);
    tick();
    chk("clr_acc_result", 32'(acc), 32'd7);
    tick();

    // Counter saturation (already 3)
    for (int i = 0; i < 256; i++) begin
      drive_req(4'd1, 4'd1, OP_AND, 1'b0);
      tick(); req_valid = 0; tick(); tick();
    end
    chk("sat_op_count", 32'(op_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
